frame_scan_reader: RTL and testbench

// - Display-side reader of the 800x480 1-bit oscilloscope frame buffer filled by the ADC plot writer.
// - Generates LCD raster timing, issues sequential read addresses to the frame-buffer RAM read port,

---
 rtl/frame_scan_reader.sv | 190 +++++++++++++++++++
 tb/tb_frame_scan_reader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: LCD raster reader for the 1-bit scope frame buffer.
// Issues sequential RAM reads and realigns pixels with delayed sync/DE.
module frame_scan_reader #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int RAM_LAT  = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int GRID_H   = 80,
  parameter int GRID_V   = 60
) (
  input  logic        clk_data_process,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rd_data,
  input  logic [15:0] fg_rgb,
  input  logic [15:0] grid_rgb,
  input  logic [15:0] bg_rgb,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GHW     = $clog2(GRID_H + 1);
  localparam int GVW     = $clog2(GRID_V + 1);
  localparam int DLY     = RAM_LAT + 1;

  logic [HW-1:0]  r_h_cnt;
  logic [VW-1:0]  r_v_cnt;
  logic [GHW-1:0] r_gh;
  logic [GVW-1:0] r_gv;

  int w_h;
  int w_v;
  int w_gh;
  int w_gv;

  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;
  logic w_grid;
  logic w_origin;

  assign w_h  = int'(r_h_cnt);
  assign w_v  = int'(r_v_cnt);
  assign w_gh = int'(r_gh);
  assign w_gv = int'(r_gv);

  assign w_h_last = (w_h == H_TOTAL - 1);
  assign w_v_last = (w_v == V_TOTAL - 1);
  assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign w_hs_on  = (w_h >= H_ACTIVE + H_FP) &&
                    (w_h <  H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_on  = (w_v >= V_ACTIVE + V_FP) &&
                    (w_v <  V_ACTIVE + V_FP + V_SYNC);
  assign w_grid   = (w_gh == 0) || (w_h == H_ACTIVE - 1) ||
                    (w_gv == 0) || (w_v == V_ACTIVE - 1);
  assign w_origin = (w_h == 0) && (w_v == 0);

  // raster position plus grid phase counters (wrap instead of divide)
  always_ff @(posedge clk_data_process or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_gh    <= '0;
      r_gv    <= '0;
    end else if (!enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_gh    <= '0;
      r_gv    <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_gh    <= '0;
      if (w_v_last) begin
        r_v_cnt <= '0;
        r_gv    <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
        r_gv    <= (w_gv == GRID_V - 1) ? '0 : r_gv + 1'b1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
      r_gh    <= (w_gh == GRID_H - 1) ? '0 : r_gh + 1'b1;
    end
  end

  logic        r_rd_en;
  logic [18:0] r_rd_addr;
  logic [18:0] r_addr_nxt;

  // read strobe and running address; holds through blanking
  always_ff @(posedge clk_data_process or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_addr_nxt <= '0;
    end else if (!enable) begin
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_addr_nxt <= '0;
    end else begin
      r_rd_en <= w_active;
      if (w_h_last && w_v_last) begin
        r_rd_addr  <= '0;
        r_addr_nxt <= '0;
      end else if (w_active) begin
        r_rd_addr  <= r_addr_nxt;
        r_addr_nxt <= r_addr_nxt + 1'b1;
      end
    end
  end

  logic [DLY-1:0] r_de_p;
  logic [DLY-1:0] r_hs_p;
  logic [DLY-1:0] r_vs_p;
  logic [DLY-1:0] r_grid_p;
  logic [DLY-1:0] r_fs_p;

  // control delay pipe; keeps draining when enable drops
  always_ff @(posedge clk_data_process or negedge rst_n) begin
    if (!rst_n) begin
      r_de_p   <= '0;
      r_hs_p   <= '0;
      r_vs_p   <= '0;
      r_grid_p <= '0;
      r_fs_p   <= '0;
    end else begin
      r_de_p   <= {r_de_p[DLY-2:0],   enable & w_active};
      r_hs_p   <= {r_hs_p[DLY-2:0],   enable & w_hs_on};
      r_vs_p   <= {r_vs_p[DLY-2:0],   enable & w_vs_on};
      r_grid_p <= {r_grid_p[DLY-2:0], enable & w_grid};
      r_fs_p   <= {r_fs_p[DLY-2:0],   enable & w_origin};
    end
  end

  logic        r_lcd_hs;
  logic        r_lcd_vs;
  logic        r_lcd_de;
  logic [15:0] r_lcd_rgb;
  logic        r_frame_start;

  // pin register: colour select with trace over grid over background
  always_ff @(posedge clk_data_process or negedge rst_n) begin
    if (!rst_n) begin
      r_lcd_hs      <= ~SYNC_POL;
      r_lcd_vs      <= ~SYNC_POL;
      r_lcd_de      <= 1'b0;
      r_lcd_rgb     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_lcd_hs      <= r_hs_p[DLY-1] ? SYNC_POL : ~SYNC_POL;
      r_lcd_vs      <= r_vs_p[DLY-1] ? SYNC_POL : ~SYNC_POL;
      r_lcd_de      <= r_de_p[DLY-1];
      r_frame_start <= r_fs_p[DLY-1];
      if (!r_de_p[DLY-1])
        r_lcd_rgb <= '0;
      else if (rd_data)
        r_lcd_rgb <= fg_rgb;
      else if (r_grid_p[DLY-1])
        r_lcd_rgb <= grid_rgb;
      else
        r_lcd_rgb <= bg_rgb;
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign lcd_hs      = r_lcd_hs;
  assign lcd_vs      = r_lcd_vs;
  assign lcd_de      = r_lcd_de;
  assign lcd_rgb     = r_lcd_rgb;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_frame_scan_reader.sv
// tb_frame_scan_reader: directed bench for the frame-buffer LCD reader.
// Full-size geometry for line timing, reduced geometry for frame-level cases.
module tb_frame_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en_a  = 1'b0;
  logic en_s  = 1'b0;
  logic [15:0] fg  = 16'hF800;
  logic [15:0] grc = 16'h07E0;
  logic [15:0] bgc = 16'h001F;

  int checks   = 0;
  int failures = 0;

  logic a_rd_data, a_rd_en, a_hs, a_vs, a_de, a_fs;
  logic [18:0] a_rd_addr;
  logic [15:0] a_rgb;
  logic b_rd_data, b_rd_en, b_hs, b_vs, b_de, b_fs;
  logic [18:0] b_rd_addr;
  logic [15:0] b_rgb;
  logic c_rd_data, c_rd_en, c_hs, c_vs, c_de, c_fs;
  logic [18:0] c_rd_addr;
  logic [15:0] c_rgb;

  frame_scan_reader #(.RAM_LAT(2)) u_a (
    .clk_data_process(clk), .rst_n(rst_n), .enable(en_a),
    .rd_data(a_rd_data), .fg_rgb(fg), .grid_rgb(grc), .bg_rgb(bgc),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .lcd_hs(a_hs),
    .lcd_vs(a_vs), .lcd_de(a_de), .lcd_rgb(a_rgb),
    .frame_start(a_fs));

  frame_scan_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RAM_LAT(1), .GRID_H(4), .GRID_V(3)
  ) u_b (
    .clk_data_process(clk), .rst_n(rst_n), .enable(en_s),
    .rd_data(b_rd_data), .fg_rgb(fg), .grid_rgb(grc), .bg_rgb(bgc),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .lcd_hs(b_hs),
    .lcd_vs(b_vs), .lcd_de(b_de), .lcd_rgb(b_rgb),
    .frame_start(b_fs));

  frame_scan_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RAM_LAT(4), .GRID_H(4), .GRID_V(3)
  ) u_c (
    .clk_data_process(clk), .rst_n(rst_n), .enable(en_s),
    .rd_data(c_rd_data), .fg_rgb(fg), .grid_rgb(grc), .bg_rgb(bgc),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .lcd_hs(c_hs),
    .lcd_vs(c_vs), .lcd_de(c_de), .lcd_rgb(c_rgb),
    .frame_start(c_fs));

  // RAM models: set pixels at fixed addresses, RAM_LAT-deep read pipes
  logic [1:0] ra_q = '0;
  logic       rb_q = 1'b0;
  logic [3:0] rc_q = '0;
  always @(posedge clk) begin
    ra_q <= {ra_q[0], a_rd_en &&
             (a_rd_addr == 19'd800 || a_rd_addr == 19'd805)};
    rb_q <= b_rd_en && (b_rd_addr == 19'd17 || b_rd_addr == 19'd20);
    rc_q <= {rc_q[2:0], c_rd_en &&
             (c_rd_addr == 19'd17 || c_rd_addr == 19'd20)};
  end
  assign a_rd_data = ra_q[1];
  assign b_rd_data = rb_q;
  assign c_rd_data = rc_q[3];

  logic        cb_rden [1:760];
  logic [18:0] cb_addr [1:760];
  logic        cb_de   [1:760];
  logic        cb_hs   [1:760];
  logic        cb_vs   [1:760];
  logic        cb_fs   [1:760];
  logic [15:0] cb_rgb  [1:760];
  logic        cc_de   [1:760];
  logic        cc_hs   [1:760];
  logic        cc_fs   [1:760];
  logic [15:0] cc_rgb  [1:760];

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_rd_en !== 1'b0) begin
      failures++; $display("FAIL rst_rd_en: got %b want 0", a_rd_en);
    end
    checks++;
    if (a_rd_addr !== 19'd0) begin
      failures++; $display("FAIL rst_rd_addr: got %0d want 0", a_rd_addr);
    end
    checks++;
    if (a_de !== 1'b0 || a_rgb !== 16'h0) begin
      failures++;
      $display("FAIL rst_de_rgb: got %b/%h want 0/0000", a_de, a_rgb);
    end
    checks++;
    if ({a_hs, a_vs} !== 2'b11) begin
      failures++; $display("FAIL rst_sync: got %b%b want 11", a_hs, a_vs);
    end
    checks++;
    if (a_fs !== 1'b0) begin
      failures++; $display("FAIL rst_fs: got %b want 0", a_fs);
    end
    checks++;
    if ({b_de, b_hs, c_de, c_hs} !== 4'b0101) begin
      failures++;
      $display("FAIL rst_small: got %b want 0101",
               {b_de, b_hs, c_de, c_hs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_line_scan();
    int last_addr, q, h, v, r, a;
    bit act, e_de, e_hs, e_vs, e_fs;
    logic [15:0] e_rgb;
    int bad_rden, bad_addr, bad_de, bad_hs, bad_vs, bad_fs, bad_rgb;
    int first_bad, hs_first, hs_low, fs_cnt;
    logic [18:0] addr801, addr1057;
    last_addr = 0; bad_rden = 0; bad_addr = 0; bad_de = 0;
    bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_rgb = 0;
    first_bad = 0; hs_first = 0; hs_low = 0; fs_cnt = 0;
    addr801 = '0; addr1057 = '0;
    @(negedge clk);
    en_a = 1'b1;
    for (int n = 1; n <= 2511; n++) begin
      @(negedge clk);
      q = n - 1; h = q % 1056; v = q / 1056;
      act = (h < 800) && (v < 480);
      if (act) last_addr = v * 800 + h;
      if (a_rd_en !== act) bad_rden++;
      if (a_rd_addr !== 19'(last_addr)) bad_addr++;
      r = n - 4;
      if (r < 0) begin
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
        e_fs = 1'b0; e_rgb = 16'h0;
      end else begin
        h = r % 1056; v = r / 1056; a = v * 800 + h;
        e_de = (h < 800) && (v < 480);
        e_hs = !(h >= 840 && h < 968);
        e_vs = !(v >= 493 && v < 496);
        e_fs = (r == 0);
        if (!e_de) e_rgb = 16'h0;
        else if (a == 800 || a == 805) e_rgb = fg;
        else if (h % 80 == 0 || h == 799 || v % 60 == 0 || v == 479)
          e_rgb = grc;
        else e_rgb = bgc;
      end
      if (a_de !== e_de) bad_de++;
      if (a_hs !== e_hs) bad_hs++;
      if (a_vs !== e_vs) bad_vs++;
      if (a_fs !== e_fs) bad_fs++;
      if (a_rgb !== e_rgb) begin
        bad_rgb++;
        if (first_bad == 0) first_bad = n;
      end
      if (a_hs === 1'b0) begin
        if (n <= 1059) hs_low++;
        if (hs_first == 0) hs_first = n;
      end
      if (a_fs === 1'b1) fs_cnt++;
      if (n == 801)  addr801  = a_rd_addr;
      if (n == 1057) addr1057 = a_rd_addr;
    end
    checks++;
    if (bad_rden !== 0) begin
      failures++; $display("FAIL scan_rd_en: %0d bad cycles want 0", bad_rden);
    end
    checks++;
    if (bad_addr !== 0) begin
      failures++; $display("FAIL scan_addr: %0d bad cycles want 0", bad_addr);
    end
    checks++;
    if (bad_de !== 0) begin
      failures++; $display("FAIL scan_de: %0d bad cycles want 0", bad_de);
    end
    checks++;
    if (bad_hs !== 0 || bad_vs !== 0) begin
      failures++;
      $display("FAIL scan_sync: hs %0d vs %0d bad cycles want 0",
               bad_hs, bad_vs);
    end
    checks++;
    if (bad_fs !== 0) begin
      failures++; $display("FAIL scan_fs: %0d bad cycles want 0", bad_fs);
    end
    checks++;
    if (bad_rgb !== 0) begin
      failures++;
      $display("FAIL scan_rgb: %0d bad cycles (first n=%0d) want 0",
               bad_rgb, first_bad);
    end
    checks++;
    if (addr801 !== 19'd799) begin
      failures++; $display("FAIL blank_hold: got %0d want 799", addr801);
    end
    checks++;
    if (addr1057 !== 19'd800) begin
      failures++; $display("FAIL line1_addr: got %0d want 800", addr1057);
    end
    checks++;
    if (hs_first !== 844) begin
      failures++; $display("FAIL hs_start: got %0d want 844", hs_first);
    end
    checks++;
    if (hs_low !== 128) begin
      failures++; $display("FAIL hs_width: got %0d want 128", hs_low);
    end
    checks++;
    if (fs_cnt !== 1) begin
      failures++; $display("FAIL fs_count: got %0d want 1", fs_cnt);
    end
  endtask

  task automatic test_enable_toggle();
    int bad_rd, bad_sync, bad_rgb, last_de, fs_at;
    logic rden1, de3;
    logic [18:0] addr1, addr2;
    logic [15:0] rgb4;
    bad_rd = 0; bad_sync = 0; bad_rgb = 0; last_de = 0; fs_at = 0;
    rden1 = 1'b0; de3 = 1'b1; addr1 = '1; addr2 = '1; rgb4 = '0;
    @(negedge clk);
    en_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_rd_en !== 1'b0 || a_rd_addr !== 19'd0) bad_rd++;
      if (a_de === 1'b1) last_de = k;
      if (a_hs !== 1'b1 || a_vs !== 1'b1) bad_sync++;
      if (k >= 4 && a_rgb !== 16'h0) bad_rgb++;
    end
    checks++;
    if (bad_rd !== 0) begin
      failures++; $display("FAIL dis_rd: %0d bad cycles want 0", bad_rd);
    end
    checks++;
    if (last_de !== 3) begin
      failures++; $display("FAIL dis_drain: last de at %0d want 3", last_de);
    end
    checks++;
    if (bad_sync !== 0 || bad_rgb !== 0) begin
      failures++;
      $display("FAIL dis_idle: sync %0d rgb %0d bad want 0",
               bad_sync, bad_rgb);
    end
    @(negedge clk);
    en_a = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (m == 1) begin rden1 = a_rd_en; addr1 = a_rd_addr; end
      if (m == 2) addr2 = a_rd_addr;
      if (m == 3) de3 = a_de;
      if (m == 4) rgb4 = a_rgb;
      if (a_fs === 1'b1 && fs_at == 0) fs_at = m;
    end
    checks++;
    if (rden1 !== 1'b1 || addr1 !== 19'd0) begin
      failures++;
      $display("FAIL reen_first: got %b/%0d want 1/0", rden1, addr1);
    end
    checks++;
    if (addr2 !== 19'd1) begin
      failures++; $display("FAIL reen_second: got %0d want 1", addr2);
    end
    checks++;
    if (fs_at !== 4) begin
      failures++; $display("FAIL reen_fs: got %0d want 4", fs_at);
    end
    checks++;
    if (de3 !== 1'b0 || rgb4 !== 16'h07E0) begin
      failures++;
      $display("FAIL reen_pix0: got %b/%h want 0/07e0", de3, rgb4);
    end
  endtask

  task automatic test_async_reset();
    checks++;
    if (a_de !== 1'b1) begin
      failures++; $display("FAIL pre_arst_de: got %b want 1", a_de);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_de !== 1'b0 || a_rgb !== 16'h0 || a_rd_en !== 1'b0 ||
        a_rd_addr !== 19'd0 || {a_hs, a_vs} !== 2'b11) begin
      failures++;
      $display("FAIL arst: de %b rgb %h en %b addr %0d want 0/0/0/0",
               a_de, a_rgb, a_rd_en, a_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int fb, fc, hb, hc;
    fb = 0; fc = 0; hb = 0; hc = 0;
    @(negedge clk);
    en_s = 1'b1;
    for (int m = 1; m <= 760; m++) begin
      @(negedge clk);
      cb_rden[m] = b_rd_en; cb_addr[m] = b_rd_addr;
      cb_de[m] = b_de; cb_hs[m] = b_hs; cb_vs[m] = b_vs;
      cb_fs[m] = b_fs; cb_rgb[m] = b_rgb;
      cc_de[m] = c_de; cc_hs[m] = c_hs;
      cc_fs[m] = c_fs; cc_rgb[m] = c_rgb;
    end
    for (int m = 1; m <= 760; m++) begin
      if (fb == 0 && cb_fs[m] === 1'b1) fb = m;
      if (fc == 0 && cc_fs[m] === 1'b1) fc = m;
      if (hb == 0 && cb_hs[m] === 1'b0) hb = m;
      if (hc == 0 && cc_hs[m] === 1'b0) hc = m;
    end
    checks++;
    if (fb !== 3) begin
      failures++; $display("FAIL lat1_fs: got %0d want 3", fb);
    end
    checks++;
    if (fc !== 6) begin
      failures++; $display("FAIL lat4_fs: got %0d want 6", fc);
    end
    checks++;
    if ({cb_de[2], cb_de[3]} !== 2'b01 || cb_rgb[3] !== 16'h07E0) begin
      failures++;
      $display("FAIL lat1_de_rgb: got %b%b/%h want 01/07e0",
               cb_de[2], cb_de[3], cb_rgb[3]);
    end
    checks++;
    if ({cc_de[5], cc_de[6]} !== 2'b01 || cc_rgb[6] !== 16'h07E0) begin
      failures++;
      $display("FAIL lat4_de_rgb: got %b%b/%h want 01/07e0",
               cc_de[5], cc_de[6], cc_rgb[6]);
    end
    checks++;
    if (hb !== 21 || hc !== 24) begin
      failures++;
      $display("FAIL lat_hs: got %0d/%0d want 21/24", hb, hc);
    end
  endtask

  task automatic test_full_frame();
    int pulses, max_addr, last_cnt, fs_cnt, fs1, fs2, vs_low, vs_first;
    pulses = 0; max_addr = 0; last_cnt = 0; fs_cnt = 0;
    fs1 = 0; fs2 = 0; vs_low = 0; vs_first = 0;
    for (int m = 1; m <= 760; m++) begin
      if (cb_rden[m] === 1'b1) begin
        if (m <= 240) pulses++;
        if (int'(cb_addr[m]) > max_addr) max_addr = int'(cb_addr[m]);
        if (m <= 240 && cb_addr[m] === 19'd95) last_cnt++;
      end
      if (cb_fs[m] === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 1) fs1 = m;
        if (fs_cnt == 2) fs2 = m;
      end
      if (cb_vs[m] === 1'b0) begin
        if (m >= 3 && m < 243) vs_low++;
        if (vs_first == 0) vs_first = m;
      end
    end
    checks++;
    if (pulses !== 96) begin
      failures++; $display("FAIL ff_pulses: got %0d want 96", pulses);
    end
    checks++;
    if (max_addr !== 95 || last_cnt !== 1) begin
      failures++;
      $display("FAIL ff_last: max %0d count %0d want 95/1",
               max_addr, last_cnt);
    end
    checks++;
    if (cb_addr[239] !== 19'd95 || cb_addr[240] !== 19'd0) begin
      failures++;
      $display("FAIL ff_wrap: got %0d/%0d want 95/0",
               cb_addr[239], cb_addr[240]);
    end
    checks++;
    if (fs_cnt !== 4 || fs2 - fs1 !== 240) begin
      failures++;
      $display("FAIL ff_fs_period: count %0d period %0d want 4/240",
               fs_cnt, fs2 - fs1);
    end
    checks++;
    if (vs_low !== 48 || vs_first !== 171) begin
      failures++;
      $display("FAIL ff_vs: low %0d start %0d want 48/171",
               vs_low, vs_first);
    end
  endtask

  task automatic test_pixels();
    int q_tab [12] = '{0, 25, 26, 28, 32, 39, 40, 77, 101, 125, 150, 265};
    logic [15:0] e_tab [12] = '{16'h07E0, 16'hF800, 16'h001F, 16'hF800,
                                16'h07E0, 16'h07E0, 16'h0000, 16'h07E0,
                                16'h001F, 16'h07E0, 16'h0000, 16'hF800};
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cb_rgb[q_tab[i] + 3] !== e_tab[i]) begin
        failures++;
        $display("FAIL pix_lat1 q=%0d: got %h want %h",
                 q_tab[i], cb_rgb[q_tab[i] + 3], e_tab[i]);
      end
      checks++;
      if (cc_rgb[q_tab[i] + 6] !== e_tab[i]) begin
        failures++;
        $display("FAIL pix_lat4 q=%0d: got %h want %h",
                 q_tab[i], cc_rgb[q_tab[i] + 6], e_tab[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_scan();
    test_enable_toggle();
    test_async_reset();
    test_latency();
    test_full_frame();
    test_pixels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
